data_mem_lsu: RTL and testbench

Next-generation data memory for the core's load/store path. Adds the following over a plain word-array memory:
- valid/ready request port with a registered, pipelined response of configurable latency;
- byte/half/word (and doubleword when WIDTH=64) stores using byte-lane merge;
- sign- and zero-extending loads;
- misalignment and out-of-range error reporting;
- sequential post-reset clear, which allows the array to map onto synthesizable RAM.

It sits between the execute/memory stage and the data array.

---
 rtl/data_mem_lsu_if.sv | 28 ++
 rtl/data_mem_lsu.sv | 172 +++++++++++++++++
 tb/tb_data_mem_lsu.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the memory stage and the data_mem_lsu array.
// Request fields are driven by the master side; response and status come back from the slave.
interface data_mem_lsu_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  rsp_err;
  logic                  init_done;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store data memory: byte-lane stores, extending loads, error reporting,
// a fixed-latency response pipeline, and a sequential clear of the array after reset.
module data_mem_lsu #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  data_mem_lsu_if.slave bus
);
  localparam int NBYTES = WIDTH / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int IDXW   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RANGE_MASK = ADDR_WIDTH'(DEPTH * NBYTES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_INIT) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == IDXW'(DEPTH - 1)) state_next = ST_RUN;
    end
  end

  assign bus.req_ready = (state_reg == ST_RUN);
  assign bus.init_done = (state_reg == ST_RUN);

  logic              accept;
  logic [IDXW-1:0]   req_idx;
  logic [OFFW-1:0]   req_off;
  logic              size_bad, misaligned, out_of_range, req_err;
  logic [NBYTES-1:0] lane_en;
  logic [WIDTH-1:0]  lane_wdata;

  assign accept       = bus.req_valid && (state_reg == ST_RUN);
  assign req_idx      = bus.req_addr[IDXW+OFFW-1:OFFW];
  assign req_off      = bus.req_addr[OFFW-1:0];
  assign size_bad     = 32'(bus.req_size) > OFFW;
  assign misaligned   = (req_off & OFFW'((32'd1 << bus.req_size) - 32'd1)) != '0;
  assign out_of_range = (bus.req_addr & ~RANGE_MASK) != '0;
  assign req_err      = size_bad | misaligned | out_of_range;

  // Access byte k lands in lane offset+k; only those lanes are enabled.
  assign lane_en    = NBYTES'(((32'd1 << (32'd1 << bus.req_size)) - 32'd1) << req_off);
  assign lane_wdata = bus.req_wdata << {req_off, 3'b000};

  logic [IDXW-1:0]   ram_addr;
  logic [NBYTES-1:0] ram_be;
  logic [WIDTH-1:0]  ram_wdata;

  always_comb begin
    ram_addr  = req_idx;
    ram_be    = '0;
    ram_wdata = lane_wdata;
    if (state_reg == ST_INIT) begin
      ram_addr  = cnt_reg;
      ram_be    = '1;
      ram_wdata = '0;
    end else if (accept && bus.req_write && !req_err) begin
      ram_be = lane_en;
    end
  end

  // No reset on the array or its read register so they map onto block RAM.
  logic [NBYTES-1:0][7:0] dmem [DEPTH];
  logic [WIDTH-1:0]       rd_word_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (ram_be[b]) dmem[ram_addr][b] <= ram_wdata[8*b +: 8];
    end
    if (accept && !bus.req_write) rd_word_q <= dmem[req_idx];
  end

  logic            s0_valid, s0_err, s0_load_ok, s0_unsigned;
  logic [1:0]      s0_size;
  logic [OFFW-1:0] s0_off;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid    <= 1'b0;
      s0_err      <= 1'b0;
      s0_load_ok  <= 1'b0;
      s0_unsigned <= 1'b0;
      s0_size     <= '0;
      s0_off      <= '0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_err      <= req_err;
        s0_load_ok  <= !bus.req_write && !req_err;
        s0_unsigned <= bus.req_unsigned;
        s0_size     <= bus.req_size;
        s0_off      <= req_off;
      end
    end
  end

  // Metadata only changes on acceptance, so the extended data holds between responses.
  logic [WIDTH-1:0] s0_shifted, s0_keep, s0_ext, s0_rdata;
  logic             s0_sign;

  always_comb begin
    s0_shifted = rd_word_q >> {s0_off, 3'b000};
    s0_keep    = '1;
    s0_sign    = s0_shifted[WIDTH-1];
    case (s0_size)
      2'd0: begin s0_keep = WIDTH'(8'hFF);         s0_sign = s0_shifted[7];  end
      2'd1: begin s0_keep = WIDTH'(16'hFFFF);      s0_sign = s0_shifted[15]; end
      2'd2: begin s0_keep = WIDTH'(32'hFFFF_FFFF); s0_sign = s0_shifted[31]; end
      default: ;
    endcase
    s0_ext   = (s0_shifted & s0_keep) | ((s0_sign && !s0_unsigned) ? ~s0_keep : '0);
    s0_rdata = s0_load_ok ? s0_ext : '0;
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign bus.rsp_valid = s0_valid;
      assign bus.rsp_rdata = s0_rdata;
      assign bus.rsp_err   = s0_err;
    end else begin : g_pipe
      logic             pv [LATENCY-1];
      logic [WIDTH-1:0] pd [LATENCY-1];
      logic             pe [LATENCY-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
            pe[i] <= 1'b0;
          end
        end else begin
          pv[0] <= s0_valid;
          if (s0_valid) begin
            pd[0] <= s0_rdata;
            pe[0] <= s0_err;
          end
          for (int i = 1; i < LATENCY - 1; i++) begin
            pv[i] <= pv[i-1];
            if (pv[i-1]) begin
              pd[i] <= pd[i-1];
              pe[i] <= pe[i-1];
            end
          end
        end
      end

      assign bus.rsp_valid = pv[LATENCY-2];
      assign bus.rsp_rdata = pd[LATENCY-2];
      assign bus.rsp_err   = pe[LATENCY-2];
    end
  endgenerate
endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized and directed bench for data_mem_lsu against a byte-array reference model
// with an in-order response scoreboard.
module tb_data_mem_lsu;
  localparam int WIDTH      = 32;
  localparam int DEPTH      = 64;
  localparam int ADDR_WIDTH = 32;
  localparam int LATENCY    = 3;
  localparam int NBYTES     = WIDTH / 8;
  localparam int MEM_BYTES  = DEPTH * NBYTES;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_lsu_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  data_mem_lsu #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_edge;
    logic [31:0] addr;
    bit          wr;
  } exp_t;

  byte unsigned ref_mem [MEM_BYTES];
  exp_t         exp_q [$];
  int           edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: memory as a flat byte array, accesses described by address arithmetic.
  function automatic exp_t model_access(bit wr, int sz, bit uns, logic [31:0] addr, logic [31:0] wdata);
    exp_t e;
    int nb = 1 << sz;
    longint unsigned v = 0;
    e.err   = (addr % nb != 0) || (nb > NBYTES) || (addr >= MEM_BYTES);
    e.rdata = '0;
    e.acc_edge = 0;
    e.addr  = addr;
    e.wr    = wr;
    if (!e.err) begin
      if (wr) begin
        for (int k = 0; k < nb; k++) ref_mem[addr + k] = wdata[8*k +: 8];
      end else begin
        for (int k = 0; k < nb; k++) v |= longint'(ref_mem[addr + k]) << (8 * k);
        if (!uns && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  task automatic issue(input bit wr, input int sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit use_k = 1'b0,
                       input logic [31:0] k_rdata = '0, input bit k_err = 1'b0);
    exp_t e;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = 2'(sz);
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    check_val("req_ready", 64'(bus.req_ready), 64'd1);
    if (bus.req_ready) begin
      e = model_access(wr, sz, uns, addr, wdata);
      if (use_k) begin
        e.rdata = k_rdata;
        e.err   = k_err;
      end
      e.acc_edge = edge_cnt + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!bus.req_ready && n < DEPTH + 20) begin
      n++;
      @(negedge clk);
    end
    check_val(tag, 64'(n), 64'(DEPTH));
    check_val("init_done", 64'(bus.init_done), 64'd1);
  endtask

  // Response monitor: in-order scoreboard, latency, and hold of idle outputs.
  exp_t        mon_e;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          rsp_n = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      last_rdata = '0;
      last_err   = 1'b0;
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
        check_val("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        check_val("rsp_latency", 64'(edge_cnt - mon_e.acc_edge), 64'(LATENCY - 1));
        $display("rsp %0d: %s addr=0x%08h rdata=0x%08h err=%0b", rsp_n,
                 mon_e.wr ? "st" : "ld", mon_e.addr, bus.rsp_rdata, bus.rsp_err);
        rsp_n++;
      end
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
    end else begin
      check_val("rsp_hold_rdata", 64'(bus.rsp_rdata), 64'(last_rdata));
      check_val("rsp_hold_err", 64'(bus.rsp_err), 64'(last_err));
    end
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = '0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_init_done", 64'(bus.init_done), 64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_val("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    reset_n = 1'b1;
    wait_init("init_cycles");

    // Cleared array: every word reads zero.
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 2, 1'b0, 32'(i * 4), '0, 1'b1, 32'h0, 1'b0);
    drain();

    issue(1'b1, 2, 1'b0, 32'h40, 32'h8070_F0A5, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 0, 1'b0, 32'h40, '0, 1'b1, 32'hFFFF_FFA5, 1'b0);
    issue(1'b0, 0, 1'b1, 32'h41, '0, 1'b1, 32'h0000_00F0, 1'b0);
    issue(1'b0, 1, 1'b0, 32'h42, '0, 1'b1, 32'hFFFF_8070, 1'b0);
    issue(1'b1, 2, 1'b0, 32'h42, 32'h1122_3344, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2, 1'b0, 32'h40, '0, 1'b1, 32'h8070_F0A5, 1'b0);
    issue(1'b0, 2, 1'b0, 32'h44, '0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 1, 1'b0, 32'h43, '0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2, 1'b0, 32'h40, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 1, 1'b0, 32'h42, 32'h0000_1234, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2, 1'b0, 32'h40, '0, 1'b1, 32'h1234_CCDD, 1'b0);
    issue(1'b0, 2, 1'b0, 32'h1000, '0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2, 1'b0, 32'h100, '0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2, 1'b0, 32'hFC, '0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 3, 1'b0, 32'h0, '0, 1'b1, 32'h0, 1'b1);
    idle(2);

    // Back-to-back store then loads; the load sees the new data.
    issue(1'b1, 2, 1'b0, 32'h8, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2, 1'b0, 32'h8, '0, 1'b1, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 2, 1'b0, 32'hC, '0, 1'b1, 32'h0, 1'b0);
    drain();

    for (int t = 0; t < 400; t++) begin
      int          sz;
      logic [31:0] addr;
      if ($urandom_range(0, 3) == 0) idle(1);
      sz   = int'($urandom_range(0, 3));
      addr = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << sz) - 1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom());
    end
    drain();

    // Reset with two loads in flight: no responses, array cleared again.
    issue(1'b1, 2, 1'b0, 32'h20, 32'h55AA_55AA, 1'b1, 32'h0, 1'b0);
    issue(1'b1, 2, 1'b0, 32'h24, 32'h0BAD_BEEF, 1'b1, 32'h0, 1'b0);
    drain();
    issue(1'b0, 2, 1'b0, 32'h20, '0);
    issue(1'b0, 2, 1'b0, 32'h24, '0);
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    #1;
    check_val("midrst_ready", 64'(bus.req_ready), 64'd0);
    check_val("midrst_init_done", 64'(bus.init_done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    reset_n = 1'b1;
    wait_init("reinit_cycles");
    issue(1'b0, 2, 1'b0, 32'h20, '0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2, 1'b0, 32'h24, '0, 1'b1, 32'h0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
